// File: rtl/mcpu_soc_timer_pkg.sv
// rtl/mcpu_soc_timer_pkg.sv - register map, CTRL bit positions and helpers for mcpu_soc_timer
package mcpu_soc_timer_pkg;

   localparam logic [1:0] REG_COUNT    = 2'd0;
   localparam logic [1:0] REG_COMPARE  = 2'd1;
   localparam logic [1:0] REG_PRESCALE = 2'd2;
   localparam logic [1:0] REG_CTRL     = 2'd3;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int CTRL_MATCH       = 8;

   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

   // Replace only the bytes whose strobe is set.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mcpu_soc_timer_prescaler.sv
// rtl/mcpu_soc_timer_prescaler.sv - enable-gated prescale counter, one tick every limit+1 enabled cycles
module mcpu_soc_timer_prescaler #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic         clear_i,
   input  logic [W-1:0] limit_i,
   output logic         tick_o
);

   logic [W-1:0] pre_cnt_q, pre_cnt_d;
   logic         at_limit;

   assign at_limit = (pre_cnt_q == limit_i);
   assign tick_o   = en_i & at_limit;

   always_comb begin
      pre_cnt_d = pre_cnt_q;
      if (clear_i) begin
         pre_cnt_d = '0;
      end else if (en_i) begin
         pre_cnt_d = at_limit ? '0 : pre_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pre_cnt_q <= '0;
      else       pre_cnt_q <= pre_cnt_d;
   end

endmodule

// File: rtl/mcpu_soc_timer.sv
// rtl/mcpu_soc_timer.sv - MMIO timer: counter, compare, sticky MATCH, auto-reload, level irq
// Prescaler is built only when MCPU_SOC_TIMER_PRESCALE_EN is defined; otherwise EN ticks every cycle.
module mcpu_soc_timer
   import mcpu_soc_timer_pkg::*;
#(
   parameter int PRESCALE_W = 16
) (
   input  logic        clkrst_core_clk,
   input  logic        clkrst_core_rst,
   input  logic [1:0]  addr,
   input  logic [31:0] data_in,
   input  logic [3:0]  write_en,
   output logic [31:0] data_out,
   output logic        irq
);

   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic                  en_q, en_d;
   logic                  reload_q, reload_d;
   logic                  irqen_q, irqen_d;
   logic                  match_q, match_d;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [31:0]           prescale_ext;
   logic                  tick;
   logic                  match_set;
   logic                  wr_count, wr_compare, wr_ctrl_lo, w1c_match;

   assign wr_count   = (addr == REG_COUNT)   && (write_en != 4'b0);
   assign wr_compare = (addr == REG_COMPARE) && (write_en != 4'b0);
   assign wr_ctrl_lo = (addr == REG_CTRL)    && write_en[0];
   assign w1c_match  = (addr == REG_CTRL)    && write_en[1] && data_in[CTRL_MATCH];

`ifdef MCPU_SOC_TIMER_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale_d;
   logic                  wr_prescale;

   assign wr_prescale = (addr == REG_PRESCALE) && (write_en != 4'b0);

   always_comb begin
      prescale_d = prescale_q;
      for (int i = 0; i < PRESCALE_W; i++) begin
         if (wr_prescale && write_en[i/8]) prescale_d[i] = data_in[i];
      end
   end

   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) prescale_q <= '0;
      else                 prescale_q <= prescale_d;
   end

   mcpu_soc_timer_prescaler #(
      .W (PRESCALE_W)
   ) u_prescaler (
      .clk_i   (clkrst_core_clk),
      .rst_i   (clkrst_core_rst),
      .en_i    (en_q),
      .clear_i (wr_prescale),
      .limit_i (prescale_q),
      .tick_o  (tick)
   );
`else
   assign prescale_q = '0;
   assign tick       = en_q;
`endif

   always_comb begin
      prescale_ext = '0;
      prescale_ext[PRESCALE_W-1:0] = prescale_q;
   end

   // A software COUNT write discards the tick entirely; unwritten bytes keep the pre-tick value.
   always_comb begin
      count_d   = count_q;
      match_set = 1'b0;
      if (tick) begin
         if (count_q == compare_q) begin
            match_set = 1'b1;
            count_d   = reload_q ? 32'h0 : count_q + 32'h1;
         end else begin
            count_d   = count_q + 32'h1;
         end
      end
      if (wr_count) count_d = byte_merge(count_q, data_in, write_en);
   end

   always_comb begin
      compare_d = compare_q;
      if (wr_compare) compare_d = byte_merge(compare_q, data_in, write_en);
   end

   always_comb begin
      en_d     = en_q;
      reload_d = reload_q;
      irqen_d  = irqen_q;
      if (wr_ctrl_lo) begin
         en_d     = data_in[CTRL_EN];
         reload_d = data_in[CTRL_AUTO_RELOAD];
         irqen_d  = data_in[CTRL_IRQ_EN];
      end
      match_d = match_set | (match_q & ~w1c_match);
   end

   always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
      if (clkrst_core_rst) begin
         count_q   <= 32'h0;
         compare_q <= COMPARE_RST;
         en_q      <= 1'b0;
         reload_q  <= 1'b0;
         irqen_q   <= 1'b0;
         match_q   <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         en_q      <= en_d;
         reload_q  <= reload_d;
         irqen_q   <= irqen_d;
         match_q   <= match_d;
      end
   end

   assign irq = match_q & irqen_q;

   always_comb begin
      data_out = 32'h0;
      case (addr)
         REG_COUNT:    data_out = count_q;
         REG_COMPARE:  data_out = compare_q;
         REG_PRESCALE: data_out = prescale_ext;
         default: begin
            data_out[CTRL_EN]          = en_q;
            data_out[CTRL_AUTO_RELOAD] = reload_q;
            data_out[CTRL_IRQ_EN]      = irqen_q;
            data_out[CTRL_MATCH]       = match_q;
         end
      endcase
   end

endmodule

// File: tb/tb_mcpu_soc_timer.sv
// tb/tb_mcpu_soc_timer.sv - directed self-checking bench for mcpu_soc_timer
module tb_mcpu_soc_timer;
   import mcpu_soc_timer_pkg::*;

`ifdef MCPU_SOC_TIMER_PRESCALE_EN
   localparam bit PRE = 1'b1;
`else
   localparam bit PRE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  addr = 2'd0;
   logic [31:0] data_in = 32'h0;
   logic [3:0]  write_en = 4'h0;
   logic [31:0] data_out;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   always #5 clk = ~clk;

   mcpu_soc_timer #(.PRESCALE_W(16)) dut (
      .clkrst_core_clk (clk),
      .clkrst_core_rst (rst),
      .addr            (addr),
      .data_in         (data_in),
      .write_en        (write_en),
      .data_out        (data_out),
      .irq             (irq)
   );

   task automatic expect_push(input string tag, input logic [31:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic compare_pop(input logic [31:0] got);
      logic [31:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      assert (got === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", t, got, e);
      end
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
      expect_push(tag, v);
      addr = a;
      #1;
      compare_pop(data_out);
   endtask

   task automatic chk_irq(input string tag, input logic v);
      expect_push(tag, {31'b0, v});
      #1;
      compare_pop({31'b0, irq});
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
      addr     = a;
      data_in  = d;
      write_en = be;
      @(posedge clk);
      #1;
      write_en = 4'h0;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cnt_m;
      logic        match_m;

      cyc(3);
      chk_reg("rst_count",    REG_COUNT,    32'h0);
      chk_reg("rst_compare",  REG_COMPARE,  32'hFFFF_FFFF);
      chk_reg("rst_prescale", REG_PRESCALE, 32'h0);
      chk_reg("rst_ctrl",     REG_CTRL,     32'h0);
      chk_irq("rst_irq", 1'b0);
      rst = 1'b0;
      cyc(1);

      // prescaled count and hold
      wr(REG_PRESCALE, 32'h3, 4'hF);
      chk_reg("pre_readback", REG_PRESCALE, PRE ? 32'h3 : 32'h0);
      wr(REG_CTRL, 32'h1, 4'hF);
      cyc(40);
      chk_reg("pre_count40", REG_COUNT, PRE ? 32'd10 : 32'd40);
      wr(REG_CTRL, 32'h0, 4'hF);
      chk_reg("hold_start", REG_COUNT, PRE ? 32'd10 : 32'd41);
      cyc(20);
      chk_reg("hold_end", REG_COUNT, PRE ? 32'd10 : 32'd41);

      // auto-reload with interrupt
      wr(REG_COUNT, 32'h0, 4'hF);
      wr(REG_COMPARE, 32'h5, 4'hF);
      wr(REG_PRESCALE, 32'h0, 4'hF);
      wr(REG_CTRL, 32'h7, 4'hF);
      cyc(5);
      chk_reg("ar_count5", REG_COUNT, 32'h5);
      chk_reg("ar_ctrl_pre", REG_CTRL, 32'h7);
      chk_irq("ar_irq_pre", 1'b0);
      cyc(1);
      chk_reg("ar_reload", REG_COUNT, 32'h0);
      chk_reg("ar_match", REG_CTRL, 32'h107);
      chk_irq("ar_irq_set", 1'b1);
      wr(REG_CTRL, 32'h107, 4'hF);
      chk_reg("ar_w1c", REG_CTRL, 32'h7);
      chk_irq("ar_irq_clr", 1'b0);
      chk_reg("ar_count1", REG_COUNT, 32'h1);

      // wrap without reload, counting continues past the match
      wr(REG_CTRL, 32'h0, 4'hF);
      wr(REG_COUNT, 32'hFFFF_FFFE, 4'hF);
      wr(REG_COMPARE, 32'h3, 4'hF);
      wr(REG_CTRL, 32'h1, 4'hF);
      cnt_m   = 32'hFFFF_FFFE;
      match_m = 1'b0;
      for (int i = 0; i < 7; i++) begin
         cyc(1);
         if (cnt_m == 32'h3) match_m = 1'b1;
         cnt_m = cnt_m + 32'h1;
         chk_reg($sformatf("wrap_count%0d", i), REG_COUNT, cnt_m);
         chk_reg($sformatf("wrap_ctrl%0d", i), REG_CTRL, {23'b0, match_m, 8'h01});
         chk_irq($sformatf("wrap_irq%0d", i), 1'b0);
      end

      // byte write to COUNT colliding with a carrying tick
      wr(REG_CTRL, 32'h100, 4'hF);
      chk_reg("coll_clr", REG_CTRL, 32'h0);
      wr(REG_COUNT, 32'h1234_56FD, 4'hF);
      wr(REG_CTRL, 32'h1, 4'hF);
      cyc(2);
      chk_reg("coll_pre", REG_COUNT, 32'h1234_56FF);
      wr(REG_COUNT, 32'hDEAD_BEAA, 4'b0001);
      chk_reg("coll_byte", REG_COUNT, 32'h1234_56AA);
      cyc(1);
      chk_reg("coll_next", REG_COUNT, 32'h1234_56AB);

      // W1C in the same cycle as a match-set
      wr(REG_CTRL, 32'h0, 4'hF);
      wr(REG_COMPARE, 32'h10, 4'hF);
      wr(REG_COUNT, 32'h0E, 4'hF);
      wr(REG_CTRL, 32'h1, 4'hF);
      cyc(2);
      chk_reg("w1c_at_cmp", REG_COUNT, 32'h10);
      wr(REG_CTRL, 32'h101, 4'hF);
      chk_reg("w1c_collide", REG_CTRL, 32'h101);
      chk_reg("w1c_count", REG_COUNT, 32'h11);
      wr(REG_CTRL, 32'h101, 4'hF);
      chk_reg("w1c_plain", REG_CTRL, 32'h1);

      // PRESCALE width and configuration
      wr(REG_CTRL, 32'h0, 4'hF);
      wr(REG_PRESCALE, 32'hFFFF_0007, 4'hF);
      chk_reg("cfg_pre7", REG_PRESCALE, PRE ? 32'h7 : 32'h0);
      wr(REG_PRESCALE, 32'h0000_AB00, 4'b0010);
      chk_reg("cfg_pre_byte", REG_PRESCALE, PRE ? 32'hAB07 : 32'h0);

      // asynchronous reset mid-state
      #1;
      rst = 1'b1;
      #1;
      chk_reg("arst_count",   REG_COUNT,    32'h0);
      chk_reg("arst_compare", REG_COMPARE,  32'hFFFF_FFFF);
      chk_reg("arst_pre",     REG_PRESCALE, 32'h0);
      chk_irq("arst_irq", 1'b0);
      cyc(1);
      rst = 1'b0;
      cyc(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
